// File: rtl/fd_instr_queue_if.sv
// Fetch-to-decode queue bundle: IFU entry in, freeze back, head entry out to D.
// The master side is the IFU/D pair, and the slave side is the queue.
interface fd_instr_queue_if #(
  parameter int DEPTH = 4
);
  logic                      F_valid;
  logic [31:0]               F_PC;
  logic [31:0]               F_instr;
  logic                      PCfreeze;
  logic                      D_stall;
  logic                      redirect;
  logic                      D_valid;
  logic [31:0]               D_PC;
  logic [31:0]               D_instr;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output F_valid, F_PC, F_instr, D_stall, redirect,
    input  PCfreeze, D_valid, D_PC, D_instr, count
  );

  modport slave (
    input  F_valid, F_PC, F_instr, D_stall, redirect,
    output PCfreeze, D_valid, D_PC, D_instr, count
  );
endinterface

// File: rtl/fd_instr_queue.sv
// Fetch-to-decode instruction FIFO with a combinational head read and a freeze back to the IFU.
// A taken branch/jump at the head discards wrong-path entries and optionally keeps the delay slot.
module fd_instr_queue #(
  parameter int DEPTH      = 4,
  parameter int DELAY_SLOT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  fd_instr_queue_if.slave      q
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] PTR_TWO = PW'(2);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TWO = CW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] wr_addr;
  logic          wr_en;
  logic          d_valid;
  logic          pop;
  logic          flush;
  logic          freeze;
  logic          push;

  assign d_valid = (count_reg != '0);
  assign pop     = d_valid & ~q.D_stall;
  assign flush   = pop & q.redirect;
  // An accepted redirect must leave the IFU free to fetch the target, even when full.
  assign freeze  = (count_reg == CNT_FULL) & ~flush;
  assign push    = q.F_valid & ~freeze & ~flush;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    wr_en       = 1'b0;
    wr_addr     = wr_ptr_reg;
    if (flush) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
      if (DELAY_SLOT != 0) begin
        if (count_reg >= CNT_TWO) begin
          // The delay slot is already queued right behind the branch; keep just that one.
          count_next  = CNT_ONE;
          wr_ptr_next = rd_ptr_reg + PTR_TWO;
        end else if (q.F_valid) begin
          // Delay slot is arriving from fetch this very cycle.
          wr_en       = 1'b1;
          wr_addr     = rd_ptr_reg + PTR_ONE;
          count_next  = CNT_ONE;
          wr_ptr_next = rd_ptr_reg + PTR_TWO;
        end else begin
          count_next  = '0;
          wr_ptr_next = rd_ptr_reg + PTR_ONE;
        end
      end else begin
        count_next  = '0;
        wr_ptr_next = rd_ptr_reg + PTR_ONE;
      end
    end else begin
      if (push) begin
        wr_en       = 1'b1;
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // Storage is deliberately not cleared; occupancy lives entirely in count and the pointers.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      pc_mem[wr_addr]    <= q.F_PC;
      instr_mem[wr_addr] <= q.F_instr;
    end
  end

  assign q.PCfreeze = freeze;
  assign q.D_valid  = d_valid;
  assign q.D_PC     = d_valid ? pc_mem[rd_ptr_reg]    : 32'h0;
  assign q.D_instr  = d_valid ? instr_mem[rd_ptr_reg] : 32'h0;
  assign q.count    = count_reg;
endmodule
